// File: rtl/audio_src_sched.sv
// Speaker source scheduler: fixed-priority grant of music/AM/beep with linear
// fade-in/fade-out gain on every switch, plus the volume/speed settings for the AM generator.
module audio_src_sched #(
  parameter int FADE_STEPS  = 16,
  parameter int STEP_CYCLES = 4096,
  parameter int VOL_DEFAULT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] src0_audio,
  input  logic [15:0] src1_audio,
  input  logic [15:0] src2_audio,
  input  logic        vol_up,
  input  logic        vol_down,
  input  logic        speed_tgl,
  input  logic        mute,
  output logic [2:0]  grant,
  output logic [15:0] audio_out,
  output logic [2:0]  volume,
  output logic [1:0]  speed,
  output logic        busy
);

  localparam int L  = $clog2(FADE_STEPS);
  localparam int GW = L + 1;
  localparam int PW = 16 + L + 1;
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [GW-1:0] GAIN_FULL = GW'(FADE_STEPS);
  localparam logic [GW-1:0] GAIN_LAST = GW'(FADE_STEPS - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FADE_IN, PLAY, FADE_OUT} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   gain, gain_next;
  logic [2:0]      cur, cur_next;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic            higher;
  logic            abort;

  assign tick   = (cnt == CNT_LAST);
  // cur is one-hot, so "higher priority" is just any request above the granted bit.
  assign higher = (cur[0] & (req[1] | req[2])) | (cur[1] & req[2]);
  assign abort  = mute | ~|(req & cur) | higher;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_next = state;
    gain_next  = gain;
    cur_next   = cur;
    unique case (state)
      IDLE: begin
        gain_next = '0;
        if (!mute && req != 3'b000) begin
          if (req[2])      cur_next = 3'b100;
          else if (req[1]) cur_next = 3'b010;
          else             cur_next = 3'b001;
          state_next = FADE_IN;
        end
      end
      FADE_IN: begin
        if (abort) begin
          state_next = FADE_OUT;
        end else if (tick) begin
          gain_next = gain + 1'b1;
          if (gain == GAIN_LAST) state_next = PLAY;
        end
      end
      PLAY: begin
        gain_next = GAIN_FULL;
        if (abort) state_next = FADE_OUT;
      end
      FADE_OUT: begin
        // Entered with gain 0 (aborted before the first step) exits on its first tick too.
        if (tick) begin
          if (gain <= GW'(1)) begin
            gain_next  = '0;
            cur_next   = 3'b000;
            state_next = IDLE;
          end else begin
            gain_next = gain - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gain  <= '0;
      cur   <= 3'b000;
      cnt   <= '0;
    end else begin
      state <= state_next;
      gain  <= gain_next;
      cur   <= cur_next;
      if (state_next != state || tick) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
    end
  end

  assign grant = cur;
  assign busy  = (state == FADE_IN) || (state == FADE_OUT);

  logic        [15:0]  sel_sample;
  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] scaled;

  always_comb begin
    sel_sample = 16'h0000;
    if (cur[2])      sel_sample = src2_audio;
    else if (cur[1]) sel_sample = src1_audio;
    else if (cur[0]) sel_sample = src0_audio;
  end

  // gain <= FADE_STEPS keeps |sample*gain| within PW signed bits, so truncation is lossless.
  assign sample_ext = {{(L + 1){sel_sample[15]}}, sel_sample};
  assign gain_ext   = {{(PW - GW){1'b0}}, gain};
  assign product    = sample_ext * gain_ext;
  assign scaled     = product >>> L;

  always_ff @(posedge clk) begin
    if (!rst)                audio_out <= 16'h0000;
    else if (state == IDLE)  audio_out <= 16'h0000;
    else                     audio_out <= scaled[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      volume <= 3'(VOL_DEFAULT);
      speed  <= 2'd1;
    end else begin
      if (vol_up && !vol_down && volume < 3'd5)      volume <= volume + 1'b1;
      else if (vol_down && !vol_up && volume > 3'd1) volume <= volume - 1'b1;
      if (speed_tgl) speed <= (speed == 2'd1) ? 2'd2 : 2'd1;
    end
  end

endmodule
